// File: rtl/eth_irq_coalescer_pkg.sv
// Shared state/cause encodings for the Ethernet RX interrupt coalescer.
package eth_irq_coalescer_pkg;

  localparam int cause_width_lp = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } coal_state_e;

  typedef enum logic [cause_width_lp-1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_COUNT   = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } fire_cause_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to a fixed value.
module bsg_dff_reset_en #(
  parameter int width_p     = 1,
  parameter int reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      data_o <= width_p'(reset_val_p);
    else if (en_i)
      data_o <= data_i;
  end

endmodule

// File: rtl/eth_sat_counter.sv
// Up-counter with clear and saturation at all-ones; clear and increment
// together yield 1, which lets the coalescer load its first packet in one step.
module eth_sat_counter #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] base;

  always_comb begin
    base = clear_i ? '0 : count_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (incr_i && (base != '1))
      count_o <= base + width_p'(1);
    else
      count_o <= base;
  end

endmodule

// File: rtl/eth_irq_coalescer.sv
// RX interrupt moderation: fire on packet count or timeout, TX passes through.
// Define ETH_IRQ_HOLDOFF_EN to add a minimum hold-off gap after each acknowledge.
module eth_irq_coalescer
  import eth_irq_coalescer_pkg::*;
#(
  parameter int count_width_p    = 8,
  parameter int timer_width_p    = 16,
  parameter int holdoff_cycles_p = 64
) (
  input  bit                       clk_i,
  input  logic                     reset_i,
  input  logic [count_width_p-1:0] pkt_thresh_i,
  input  logic                     pkt_thresh_v_i,
  input  logic [timer_width_p-1:0] timeout_i,
  input  logic                     timeout_v_i,
  input  logic                     rx_pending_i,
  input  logic                     rx_arrival_i,
  input  logic                     tx_interrupt_i,
  input  logic                     irq_ack_i,
  output logic                     rx_irq_o,
  output logic                     irq_o,
  output logic [cause_width_lp-1:0] fire_cause_o,
  output logic [count_width_p-1:0] pkt_count_o
);

  logic [count_width_p-1:0] pkt_thresh_r, count_r;
  logic [timer_width_p-1:0] timeout_r, timer_r;
  coal_state_e              state_r, state_n;
  fire_cause_e              cause_r, cause_n;
  logic                     count_clear, count_incr, timer_clear, timer_incr;
  logic                     count_hit, timeout_hit, fire;

  bsg_dff_reset_en #(.width_p(count_width_p), .reset_val_p(1)) thresh_reg (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(pkt_thresh_v_i),
    .data_i(pkt_thresh_i), .data_o(pkt_thresh_r)
  );

  bsg_dff_reset_en #(.width_p(timer_width_p), .reset_val_p(0)) timeout_reg (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(timeout_v_i),
    .data_i(timeout_i), .data_o(timeout_r)
  );

  eth_sat_counter #(.width_p(count_width_p)) pkt_counter (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(count_clear),
    .incr_i(count_incr), .count_o(count_r)
  );

  eth_sat_counter #(.width_p(timer_width_p)) age_timer (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(timer_clear),
    .incr_i(timer_incr), .count_o(timer_r)
  );

  // A zero timeout disables the time term; a zero threshold makes the count term always true.
  assign count_hit   = (count_r >= pkt_thresh_r);
  assign timeout_hit = (timeout_r != '0) && (timer_r >= timeout_r);
  assign fire        = count_hit || timeout_hit;

`ifdef ETH_IRQ_HOLDOFF_EN
  localparam int holdoff_width_lp = $clog2(holdoff_cycles_p + 1);
  localparam logic [holdoff_width_lp-1:0] holdoff_last_lp =
    holdoff_width_lp'(holdoff_cycles_p - 1);

  logic [holdoff_width_lp-1:0] holdoff_r;
  logic                        holdoff_done;

  always_ff @(posedge clk_i) begin
    if (reset_i || (state_r != HOLDOFF))
      holdoff_r <= '0;
    else
      holdoff_r <= holdoff_r + holdoff_width_lp'(1);
  end

  assign holdoff_done = (holdoff_r == holdoff_last_lp);
`else
  logic unused_holdoff;
  assign unused_holdoff = (holdoff_cycles_p > 0);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= state_n;
      cause_r <= cause_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    cause_n     = cause_r;
    count_clear = 1'b0;
    count_incr  = 1'b0;
    timer_clear = 1'b0;
    timer_incr  = 1'b0;
    case (state_r)
      IDLE: begin
        count_clear = 1'b1;
        timer_clear = 1'b1;
        count_incr  = rx_pending_i;
        if (rx_pending_i)
          state_n = COLLECT;
      end
      COLLECT: begin
        if (fire) begin
          state_n    = ASSERT;
          cause_n    = count_hit ? CAUSE_COUNT : CAUSE_TIMEOUT;
          count_incr = rx_arrival_i;
          timer_incr = 1'b1;
        end else if (!rx_pending_i) begin
          state_n     = IDLE;
          count_clear = 1'b1;
          timer_clear = 1'b1;
        end else begin
          count_incr = rx_arrival_i;
          timer_incr = 1'b1;
        end
      end
      ASSERT: begin
        if (irq_ack_i || !rx_pending_i) begin
          state_n     = IDLE;
          cause_n     = CAUSE_NONE;
          count_clear = 1'b1;
          timer_clear = 1'b1;
`ifdef ETH_IRQ_HOLDOFF_EN
          if (irq_ack_i)
            state_n = HOLDOFF;
`endif
        end
      end
`ifdef ETH_IRQ_HOLDOFF_EN
      HOLDOFF: begin
        count_clear = 1'b1;
        timer_clear = 1'b1;
        if (holdoff_done)
          state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rx_irq_o     = (state_r == ASSERT);
  assign irq_o        = rx_irq_o | tx_interrupt_i;
  assign fire_cause_o = cause_r;
  assign pkt_count_o  = count_r;

endmodule

// File: tb/tb_eth_irq_coalescer.sv
// Self-checking bench for eth_irq_coalescer: directed scenarios with literal
// expectations plus a per-cycle comparison against an episode-level model.
module tb_eth_irq_coalescer;

  localparam int cw   = 8;
  localparam int tw   = 16;
  localparam int hold = 8;

  bit            clk;
  logic          reset;
  logic [cw-1:0] pkt_thresh;
  logic          pkt_thresh_v;
  logic [tw-1:0] timeout;
  logic          timeout_v;
  logic          rx_pending, rx_arrival, tx, irq_ack;
  logic          rx_irq, irq;
  logic [1:0]    cause;
  logic [cw-1:0] pkt_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  eth_irq_coalescer #(
    .count_width_p(cw), .timer_width_p(tw), .holdoff_cycles_p(hold)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .pkt_thresh_i(pkt_thresh), .pkt_thresh_v_i(pkt_thresh_v),
    .timeout_i(timeout), .timeout_v_i(timeout_v),
    .rx_pending_i(rx_pending), .rx_arrival_i(rx_arrival),
    .tx_interrupt_i(tx), .irq_ack_i(irq_ack),
    .rx_irq_o(rx_irq), .irq_o(irq),
    .fire_cause_o(cause), .pkt_count_o(pkt_count)
  );

  always #5 clk = ~clk;

  // Episode model: is a batch being gathered, has the interrupt been raised,
  // how many hold-off cycles remain, and the packet/age tallies of the batch.
  bit m_collecting = 1'b0;
  bit m_raised     = 1'b0;
  int m_hold_left  = 0;
  int m_pkts       = 0;
  int m_age        = 0;
  int m_cause      = 0;
  int m_thresh     = 1;
  int m_timeout    = 0;
  bit m_count_hit, m_time_hit;

  always @(posedge clk) begin
    if (reset) begin
      m_collecting = 1'b0;
      m_raised     = 1'b0;
      m_hold_left  = 0;
      m_pkts       = 0;
      m_age        = 0;
      m_cause      = 0;
      m_thresh     = 1;
      m_timeout    = 0;
    end else begin
      m_count_hit = (m_pkts >= m_thresh);
      m_time_hit  = (m_timeout != 0) && (m_age >= m_timeout);
      if (m_raised) begin
        if (irq_ack || !rx_pending) begin
          m_raised = 1'b0;
          m_pkts   = 0;
          m_age    = 0;
          m_cause  = 0;
`ifdef ETH_IRQ_HOLDOFF_EN
          if (irq_ack) m_hold_left = hold;
`endif
        end
      end else if (m_hold_left > 0) begin
        m_hold_left = m_hold_left - 1;
      end else if (m_collecting) begin
        if (m_count_hit || m_time_hit) begin
          m_collecting = 1'b0;
          m_raised     = 1'b1;
          m_cause      = m_count_hit ? 1 : 2;
          if (rx_arrival && m_pkts < 255) m_pkts = m_pkts + 1;
          if (m_age < 65535) m_age = m_age + 1;
        end else if (!rx_pending) begin
          m_collecting = 1'b0;
          m_pkts       = 0;
          m_age        = 0;
        end else begin
          if (rx_arrival && m_pkts < 255) m_pkts = m_pkts + 1;
          if (m_age < 65535) m_age = m_age + 1;
        end
      end else if (rx_pending) begin
        m_collecting = 1'b1;
        m_pkts       = 1;
        m_age        = 0;
      end else begin
        m_pkts = 0;
        m_age  = 0;
      end
      if (pkt_thresh_v) m_thresh = int'(pkt_thresh);
      if (timeout_v)    m_timeout = int'(timeout);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_rx_irq", 32'(rx_irq), 32'(m_raised));
      checkOutput("model_fire_cause", 32'(cause), m_cause);
      checkOutput("model_pkt_count", 32'(pkt_count), m_pkts);
      checkOutput("model_irq", 32'(irq), 32'(m_raised | tx));
    end
  end

  // Advance to 2 time units after the next rising edge; TX toggles every cycle.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      tx = ~tx;
    end
  endtask

  task automatic applyStimulus(input bit pend, input bit arr, input bit ack);
    rx_pending = pend;
    rx_arrival = arr;
    irq_ack    = ack;
  endtask

  task automatic writeConfig(input int thresh, input int tmo);
    pkt_thresh   = cw'(thresh);
    timeout      = tw'(tmo);
    pkt_thresh_v = 1'b1;
    timeout_v    = 1'b1;
    stepCycles(1);
    pkt_thresh_v = 1'b0;
    timeout_v    = 1'b0;
  endtask

  task automatic ackAndDrop();
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ack_clears_irq", 32'(rx_irq), 0);
    checkOutput("ack_clears_count", 32'(pkt_count), 0);
    stepCycles(2);
  endtask

  initial begin
    reset = 1'b1; tx = 1'b0;
    pkt_thresh = '0; pkt_thresh_v = 1'b0; timeout = '0; timeout_v = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    cmp_en = 1'b1;
    checkOutput("reset_rx_irq", 32'(rx_irq), 0);
    checkOutput("reset_cause", 32'(cause), 0);
    checkOutput("reset_count", 32'(pkt_count), 0);
    reset = 1'b0;
    stepCycles(3);

    // Defaults: fire on the first COLLECT cycle, then ack with pending held high.
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("dflt_collect_irq", 32'(rx_irq), 0);
    checkOutput("dflt_collect_count", 32'(pkt_count), 1);
    stepCycles(1);
    checkOutput("dflt_fire_irq", 32'(rx_irq), 1);
    checkOutput("dflt_fire_cause", 32'(cause), 1);
    checkOutput("dflt_fire_count", 32'(pkt_count), 1);
    stepCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("dflt_ack_irq", 32'(rx_irq), 0);
    checkOutput("dflt_ack_cause", 32'(cause), 0);
`ifdef ETH_IRQ_HOLDOFF_EN
    stepCycles(8);
    checkOutput("hold_idle_irq", 32'(rx_irq), 0);
    checkOutput("hold_idle_count", 32'(pkt_count), 0);
    stepCycles(1);
    checkOutput("hold_collect_count", 32'(pkt_count), 1);
    checkOutput("hold_collect_irq", 32'(rx_irq), 0);
    stepCycles(1);
    checkOutput("hold_refire_irq", 32'(rx_irq), 1);
`else
    stepCycles(1);
    checkOutput("refire_collect_count", 32'(pkt_count), 1);
    checkOutput("refire_collect_irq", 32'(rx_irq), 0);
    stepCycles(1);
    checkOutput("refire_irq", 32'(rx_irq), 1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("drop_in_assert_irq", 32'(rx_irq), 0);
    checkOutput("drop_in_assert_cause", 32'(cause), 0);
    stepCycles(2);

    // Threshold 0 with timeout 0 behaves like threshold 1.
    writeConfig(0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("thr0_irq", 32'(rx_irq), 1);
    checkOutput("thr0_cause", 32'(cause), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);

    // Threshold 4: three arrivals after pending; a stray ack in COLLECT is ignored.
    writeConfig(4, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("thr4_count_mid", 32'(pkt_count), 2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("thr4_pre_irq", 32'(rx_irq), 0);
    checkOutput("thr4_pre_count", 32'(pkt_count), 4);
    stepCycles(1);
    checkOutput("thr4_irq", 32'(rx_irq), 1);
    checkOutput("thr4_count", 32'(pkt_count), 4);
    checkOutput("thr4_cause", 32'(cause), 1);
    ackAndDrop();

    // Timeout path: threshold unreachable, timeout 50.
    writeConfig(200, 50);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    stepCycles(50);
    checkOutput("tmo_pre_irq", 32'(rx_irq), 0);
    stepCycles(1);
    checkOutput("tmo_irq", 32'(rx_irq), 1);
    checkOutput("tmo_cause", 32'(cause), 2);
    checkOutput("tmo_count", 32'(pkt_count), 1);
    ackAndDrop();

    // Count and timeout both true on the same cycle: count wins.
    writeConfig(3, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    stepCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("tie_count_mid", 32'(pkt_count), 2);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tie_pre_irq", 32'(rx_irq), 0);
    checkOutput("tie_pre_count", 32'(pkt_count), 3);
    stepCycles(1);
    checkOutput("tie_irq", 32'(rx_irq), 1);
    checkOutput("tie_cause", 32'(cause), 1);
    ackAndDrop();

    // Pending drops in COLLECT before any fire term is met.
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("drain_collect_count", 32'(pkt_count), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("drain_count", 32'(pkt_count), 0);
    checkOutput("drain_irq", 32'(rx_irq), 0);
    stepCycles(2);

    // Reset mid-COLLECT restores threshold 1, then reset mid-ASSERT.
    writeConfig(5, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(2);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("rst_collect_irq", 32'(rx_irq), 0);
    checkOutput("rst_collect_cause", 32'(cause), 0);
    checkOutput("rst_collect_count", 32'(pkt_count), 0);
    stepCycles(2);
    checkOutput("rst_thresh_restored_irq", 32'(rx_irq), 1);
    checkOutput("rst_thresh_restored_cause", 32'(cause), 1);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("rst_assert_irq", 32'(rx_irq), 0);
    checkOutput("rst_assert_cause", 32'(cause), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
